mby_igr_epl_shim_seg_ctl: RTL
=============================

# mby_igr_epl_shim_seg_ctl

Sequencing controller for the ingress EPL shim segment registers. It sits between the EPL receive interface and a ring of `NUM_SEG` 64B segment-register instances. It packs each cycle's valid 8B words into 64B packet-buffer-aligned segments by driving every instance's per-lane selects, write enables, segment-close and SOP-capture strobes. It also arbitrates completed segments toward the packet buffer (PB) write port in fill order.

## Interface
- `NUM_SEG`, 3: segment instances in the ring; minimum 3, because one unaligned EOP+SOP cycle can touch three segments.
- `SEG_IDX_W`, `$clog2(NUM_SEG)`: slot index width.
- `cclk` in 1: core clock; single clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `i_rx_v` in 1: EPL word group valid this cycle.
- `i_rx_md` in `epl_md_t`: fields used are `sop`, `sop_pos[2:0]`, `eop`, `eop_pos[2:0]` (word indices).
- `o_seg_sel` out `[NUM_SEG] shimfsel_t`: per slot, per lane s0..s7 source select; 0–7 selects an input word, 8 selects pad.
- `o_seg_we` out `[NUM_SEG][7:0]`: per-lane write enable.
- `o_seg_e` out `[NUM_SEG]`: segment-close strobe (metadata capture).
- `o_seg_sop_e` out `[NUM_SEG]`: SOP metadata capture for a partial segment opened by SOP.
- `o_pb_req` out 1: a closed segment is ready for the PB.
- `o_pb_seg_idx` out `SEG_IDX_W`: slot being offered.
- `i_pb_gnt` in 1: PB accepts the offered slot this cycle.
- `o_ovf_err` out 1: sticky overflow flag, cleared only by `rst`.

## Operation
- Valid words per cycle, with `i_rx_v=1`:
  - mid-packet: words 0..7
  - SOP only: `sop_pos`..7
  - EOP only: 0..`eop_pos`
  - SOP and EOP with `sop_pos<=eop_pos`: `sop_pos`..`eop_pos`, a single-cycle packet
  - SOP and EOP with `sop_pos>eop_pos`: EOP piece 0..`eop_pos` followed by SOP piece `sop_pos`..7
- State machine:
  - IDLE to PKT on SOP without a same-piece EOP.
  - PKT to IDLE on EOP.
  - An unaligned EOP+SOP stays in PKT.
  - Words arriving in IDLE without SOP are dropped silently.
- State registers:
  - `cur` is the open slot index.
  - `fill[3:0]` is the number of lanes written in `cur` (0..8).
- Lane mapping: word j goes to lane `(fill + j - first)`. Lanes 0..7 land in `cur`; lanes 8..15 spill to lanes 0..7 of `cur+1` mod `NUM_SEG`. Asserted `we` bits equal exactly the lanes written.
- Closing a segment:
  - Close when it reaches 8 lanes, or when EOP is in it.
  - Close means `o_seg_e[slot]=1` that cycle.
  - On an EOP close, unwritten lanes get sel=8 with `we=1` (pad).
  - After a close, `cur` advances and `fill` resets to the number of spilled lanes, or to 0.
- The SOP piece of an unaligned EOP+SOP always opens a fresh slot:
  - It asserts `o_seg_sop_e` on that slot.
  - It does not assert `o_seg_e` unless the piece alone fills 8 lanes, i.e. `sop_pos=0`, which is impossible here.
- SOP starting an empty slot under any other condition: assert `o_seg_sop_e` only if the slot is not also closed that cycle.
- Closed slots enter an in-order pending FIFO of depth `NUM_SEG`. The head drives `o_pb_seg_idx`, and `o_pb_req` is asserted while the FIFO is non-empty. `i_pb_gnt` pops the head and frees the slot.
- Overflow: a cycle needing a slot that is still pending.
  - All writes for that cycle are suppressed.
  - `o_ovf_err` is set.
  - The FSM goes to IDLE with `fill=0`.
  - Pending slots are preserved.
- `rst` mid-packet aborts the packet.
  - All state clears.
  - The pending FIFO empties.
  - Slot contents are not flushed.

## Timing
- Reset values:
  - `o_seg_we`, `o_seg_e`, `o_seg_sop_e`, `o_pb_req`, `o_ovf_err` = 0
  - `o_seg_sel` = all lanes 8
  - `o_pb_seg_idx` = 0
  - `cur=0`, `fill=0`, state IDLE
- Strobe outputs are combinational from the `i_rx_*` inputs and the registered state; they are asserted in the same cycle as `i_rx_v`.
- A slot closed in cycle t appears at the FIFO head, with `o_pb_req` asserted, no earlier than t+1. That is the cycle the segment registers hold the data.
- `i_pb_gnt` in the same cycle as an `i_rx_v` that needs the head slot frees it in time: grant wins, and there is no overflow.
- `i_pb_gnt` with `o_pb_req=0` is ignored.

## Configuration
- `MBY_IGR_SEG_CTL_STATS_EN` defined: adds the following outputs.
  - `o_stat_seg_cnt[31:0]`: closed segments.
  - `o_stat_pad_cnt[31:0]`: padded segments.
  - `o_stat_ovf_cnt[15:0]`: overflow events, saturating.
  - All counters clear on `rst`; the 32-bit counters wrap.
- Not defined: these ports are absent, and the counters are not built.

## Structure
- `mby_igr_pkg` holds:
  - `SHIM_SEL_PAD = 4'h8`
  - `SHIM_SEG_LANES = 8`
  - a `seg_ctl_state_e` enum (IDLE, PKT)
  - `shimfsel_t`
- Sub-module `mby_igr_seg_ctl_pend_fifo`: the in-order slot-index FIFO with full/empty flags.

## Test plan
- Aligned 128B packet (SOP pos 0, then EOP pos 7, one cycle each) -> slots 0 and 1 close in consecutive cycles with all `we=FF`; `o_pb_req` shows idx 0 then 1.
- SOP at pos 5 then EOP at pos 2 -> slot 0 takes 3+3 words; EOP closes it with lanes 6,7 set to sel 8; `o_seg_sop_e[0]=1` on the first cycle.
- Unaligned EOP pos 3 plus SOP pos 6 with `fill=6` -> slot 0 closes with 8 lanes; slot 1 gets 2 words, closes, and pads 6 lanes; slot 2 is opened by SOP with `sop_e=1` and `fill=2`.
- Hold `i_pb_gnt=0` over 4 full segments -> the 4th needs slot 0 while it is pending: no writes that cycle, `o_ovf_err=1`, 3 requests remain.
- `rst` asserted with `fill=5` in PKT -> next cycle IDLE, `fill=0`, `o_pb_req=0`; non-SOP words are dropped until the next SOP.
- With `MBY_IGR_SEG_CTL_STATS_EN` defined: scenario 2 -> `seg_cnt=1`, `pad_cnt=1`.

Source files
------------

// File: rtl/mby_igr_pkg.sv
// Shared types and constants for the ingress EPL shim segment controller.
package mby_igr_pkg;

    localparam int         SHIM_SEG_LANES = 8;
    localparam logic [3:0] SHIM_SEL_PAD   = 4'h8;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } seg_ctl_state_e;

    // Per-lane source select, lane 0 in the low nibble; 0-7 picks an input word, 8 pads.
    typedef logic [SHIM_SEG_LANES-1:0][3:0] shimfsel_t;

    localparam shimfsel_t SEL_ALL_PAD = {SHIM_SEG_LANES{SHIM_SEL_PAD}};

    typedef struct packed {
        logic       sop;
        logic [2:0] sop_pos;
        logic       eop;
        logic [2:0] eop_pos;
    } epl_md_t;

    function automatic logic [4:0] piece_len(input logic [2:0] first, input logic [2:0] last);
        return 5'(last) - 5'(first) + 5'd1;
    endfunction

endpackage

// File: rtl/mby_igr_seg_ctl_pend_fifo.sv
// In-order FIFO of closed slot indices awaiting the packet buffer; accepts up to
// two pushes per cycle and exposes a bitmap of the slots currently queued.
module mby_igr_seg_ctl_pend_fifo
    import mby_igr_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             cclk,
    input  logic             rst,
    input  logic             push0,
    input  logic [IDX_W-1:0] idx0,
    input  logic             push1,
    input  logic [IDX_W-1:0] idx1,
    input  logic             pop,
    output logic [IDX_W-1:0] head,
    output logic             empty,
    output logic             full,
    output logic [DEPTH-1:0] pend
);

    logic [IDX_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0] rd_ptr;
    logic [IDX_W-1:0] wr_ptr;
    logic [IDX_W:0]   count;
    logic [1:0]       n_push;
    logic             pop_eff;
    logic [IDX_W-1:0] first_idx;

    function automatic logic [IDX_W-1:0] ptr_add(input logic [IDX_W-1:0] p, input logic [IDX_W:0] n);
        logic [IDX_W+1:0] s;
        s = (IDX_W+2)'(p) + (IDX_W+2)'(n);
        if (s >= (IDX_W+2)'(DEPTH))
            s = s - (IDX_W+2)'(DEPTH);
        return IDX_W'(s);
    endfunction

    assign empty     = (count == '0);
    assign full      = (count == (IDX_W+1)'(DEPTH));
    assign head      = mem[rd_ptr];
    assign pop_eff   = pop & ~empty;
    assign n_push    = {1'b0, push0} + {1'b0, push1};
    assign first_idx = push0 ? idx0 : idx1;

    always_ff @(posedge cclk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (push0 | push1)
                mem[wr_ptr] <= first_idx;
            if (push0 & push1)
                mem[ptr_add(wr_ptr, (IDX_W+1)'(1))] <= idx1;
            wr_ptr <= ptr_add(wr_ptr, (IDX_W+1)'(n_push));
            if (pop_eff)
                rd_ptr <= ptr_add(rd_ptr, (IDX_W+1)'(1));
            count <= count + (IDX_W+1)'(n_push) - (IDX_W+1)'(pop_eff);
        end
    end

    always_comb begin
        pend = '0;
        for (int i = 0; i < DEPTH; i++)
            if ((IDX_W+1)'(i) < count)
                pend[mem[ptr_add(rd_ptr, (IDX_W+1)'(i))]] = 1'b1;
    end

endmodule

// File: rtl/mby_igr_epl_shim_seg_ctl.sv
// Packs EPL 8B words into 64B segment slots and offers closed slots to the PB in order.
// Optional statistics counters: define MBY_IGR_SEG_CTL_STATS_EN.
//
// state | meaning
// IDLE  | outside a packet; non-SOP words are dropped
// PKT   | packet open; cur/fill track the partially filled slot
module mby_igr_epl_shim_seg_ctl
    import mby_igr_pkg::*;
#(
    parameter int NUM_SEG   = 3,
    parameter int SEG_IDX_W = $clog2(NUM_SEG)
) (
    input  logic                       cclk,
    input  logic                       rst,
    input  logic                       i_rx_v,
    input  epl_md_t                    i_rx_md,
    output shimfsel_t [NUM_SEG-1:0]    o_seg_sel,
    output logic [NUM_SEG-1:0][7:0]    o_seg_we,
    output logic [NUM_SEG-1:0]         o_seg_e,
    output logic [NUM_SEG-1:0]         o_seg_sop_e,
    output logic                       o_pb_req,
    output logic [SEG_IDX_W-1:0]       o_pb_seg_idx,
    input  logic                       i_pb_gnt,
`ifdef MBY_IGR_SEG_CTL_STATS_EN
    output logic [31:0]                o_stat_seg_cnt,
    output logic [31:0]                o_stat_pad_cnt,
    output logic [15:0]                o_stat_ovf_cnt,
`endif
    output logic                       o_ovf_err
);

    seg_ctl_state_e          state;
    logic [SEG_IDX_W-1:0]    cur;
    logic [3:0]              fill;

    logic                    acc_a, acc_b, sop_a, eop_a;
    logic [2:0]              fa, la;
    logic [4:0]              na, fill_x, end_a, b_base, nb, a_pad_end, lane;
    logic                    spill, close0, close1;
    logic [1:0]              a_slots, rb;
    logic [2:0][7:0]         rel_we;
    shimfsel_t [2:0]         rel_sel;
    logic [2:0]              rel_e, rel_sop_e;
    logic [SEG_IDX_W-1:0]    slot_of [3];
    logic [NUM_SEG-1:0][7:0] we_c;
    shimfsel_t [NUM_SEG-1:0] sel_c;
    logic [NUM_SEG-1:0]      e_c, sop_e_c, need_c, pend, pend_eff, head_mask;
    logic [SEG_IDX_W-1:0]    head;
    logic                    empty, full, gnt_eff, ovf_c;

    function automatic logic [SEG_IDX_W-1:0] slot_add(input logic [SEG_IDX_W-1:0] base, input logic [1:0] r);
        logic [SEG_IDX_W+1:0] s;
        s = (SEG_IDX_W+2)'(base) + (SEG_IDX_W+2)'(r);
        if (s >= (SEG_IDX_W+2)'(NUM_SEG))
            s = s - (SEG_IDX_W+2)'(NUM_SEG);
        return SEG_IDX_W'(s);
    endfunction

    // Piece A is everything up to and including EOP; piece B is the SOP tail of an unaligned EOP+SOP.
    always_comb begin
        acc_a = 1'b0;
        acc_b = 1'b0;
        sop_a = 1'b0;
        eop_a = 1'b0;
        fa    = 3'd0;
        la    = 3'd7;
        if (i_rx_v) begin
            if (!i_rx_md.sop && !i_rx_md.eop) begin
                acc_a = (state == PKT);
            end else if (i_rx_md.sop && !i_rx_md.eop) begin
                acc_a = 1'b1;
                sop_a = 1'b1;
                fa    = i_rx_md.sop_pos;
            end else if (!i_rx_md.sop) begin
                acc_a = (state == PKT);
                eop_a = 1'b1;
                la    = i_rx_md.eop_pos;
            end else if (i_rx_md.sop_pos <= i_rx_md.eop_pos) begin
                acc_a = 1'b1;
                sop_a = 1'b1;
                eop_a = 1'b1;
                fa    = i_rx_md.sop_pos;
                la    = i_rx_md.eop_pos;
            end else begin
                acc_a = (state == PKT);
                eop_a = 1'b1;
                la    = i_rx_md.eop_pos;
                acc_b = 1'b1;
            end
        end
    end

    assign na        = piece_len(fa, la);
    assign fill_x    = {1'b0, fill};
    assign end_a     = fill_x + na;
    assign spill     = (end_a > 5'd8);
    assign a_slots   = spill ? 2'd2 : 2'd1;
    assign close0    = acc_a & ((end_a >= 5'd8) | eop_a);
    assign close1    = acc_a & spill & eop_a;
    assign rb        = acc_a ? a_slots : 2'd0;
    assign b_base    = {rb, 3'b000};
    assign nb        = 5'd8 - 5'(i_rx_md.sop_pos);
    assign a_pad_end = {a_slots, 3'b000};

    // Lanes are laid out in a three-slot window starting at cur.
    always_comb begin
        rel_we    = '0;
        rel_sel   = {3{SEL_ALL_PAD}};
        rel_e     = {1'b0, close1, close0};
        rel_sop_e = '0;
        lane      = '0;
        for (int r = 0; r < 3; r++) begin
            for (int l = 0; l < 8; l++) begin
                lane = 5'(r * 8 + l);
                if (acc_a && lane >= fill_x && lane < end_a) begin
                    rel_we[r][l]  = 1'b1;
                    rel_sel[r][l] = 4'(5'(fa) + lane - fill_x);
                end else if (acc_a && eop_a && lane >= end_a && lane < a_pad_end) begin
                    rel_we[r][l]  = 1'b1;
                end
                if (acc_b && lane >= b_base && lane < b_base + nb) begin
                    rel_we[r][l]  = 1'b1;
                    rel_sel[r][l] = 4'(5'(i_rx_md.sop_pos) + lane - b_base);
                end
            end
        end
        if (acc_a && sop_a && fill == 4'd0 && !close0)
            rel_sop_e[0] = 1'b1;
        if (acc_b)
            rel_sop_e[rb] = 1'b1;
    end

    always_comb begin
        we_c    = '0;
        sel_c   = {NUM_SEG{SEL_ALL_PAD}};
        e_c     = '0;
        sop_e_c = '0;
        need_c  = '0;
        for (int r = 0; r < 3; r++) begin
            slot_of[r]          = slot_add(cur, 2'(r));
            we_c[slot_of[r]]    = rel_we[r];
            sel_c[slot_of[r]]   = rel_sel[r];
            e_c[slot_of[r]]     = rel_e[r];
            sop_e_c[slot_of[r]] = rel_sop_e[r];
            need_c[slot_of[r]]  = |rel_we[r];
        end
    end

    // A grant in the same cycle releases the head slot before the overflow check.
    assign gnt_eff   = i_pb_gnt & ~empty;
    assign head_mask = gnt_eff ? (NUM_SEG'(1) << head) : '0;
    assign pend_eff  = pend & ~head_mask;
    assign ovf_c     = i_rx_v & ((|need_c & full & ~gnt_eff) | (|(need_c & pend_eff)));

    assign o_seg_we     = ovf_c ? '0 : we_c;
    assign o_seg_sel    = ovf_c ? {NUM_SEG{SEL_ALL_PAD}} : sel_c;
    assign o_seg_e      = ovf_c ? '0 : e_c;
    assign o_seg_sop_e  = ovf_c ? '0 : sop_e_c;
    assign o_pb_req     = ~empty;
    assign o_pb_seg_idx = empty ? '0 : head;

    mby_igr_seg_ctl_pend_fifo #(
        .DEPTH (NUM_SEG),
        .IDX_W (SEG_IDX_W)
    ) u_pend_fifo (
        .cclk  (cclk),
        .rst   (rst),
        .push0 (close0 & ~ovf_c),
        .idx0  (slot_of[0]),
        .push1 (close1 & ~ovf_c),
        .idx1  (slot_of[1]),
        .pop   (i_pb_gnt),
        .head  (head),
        .empty (empty),
        .full  (full),
        .pend  (pend)
    );

    always_ff @(posedge cclk) begin
        if (rst) begin
            state     <= IDLE;
            cur       <= '0;
            fill      <= '0;
            o_ovf_err <= 1'b0;
        end else if (ovf_c) begin
            state     <= IDLE;
            fill      <= '0;
            o_ovf_err <= 1'b1;
        end else if (acc_b) begin
            state <= PKT;
            cur   <= slot_of[rb];
            fill  <= 4'(nb);
        end else if (acc_a) begin
            if (eop_a) begin
                state <= IDLE;
                cur   <= slot_of[a_slots];
                fill  <= '0;
            end else if (end_a >= 5'd8) begin
                state <= PKT;
                cur   <= slot_of[1];
                fill  <= 4'(end_a - 5'd8);
            end else begin
                state <= PKT;
                fill  <= 4'(end_a);
            end
        end
    end

`ifdef MBY_IGR_SEG_CTL_STATS_EN
    logic pad0, pad1;

    assign pad0 = acc_a & eop_a & (end_a < 5'd8);
    assign pad1 = close1 & (end_a < 5'd16);

    always_ff @(posedge cclk) begin
        if (rst) begin
            o_stat_seg_cnt <= '0;
            o_stat_pad_cnt <= '0;
            o_stat_ovf_cnt <= '0;
        end else if (ovf_c) begin
            if (o_stat_ovf_cnt != 16'hFFFF)
                o_stat_ovf_cnt <= o_stat_ovf_cnt + 16'd1;
        end else begin
            o_stat_seg_cnt <= o_stat_seg_cnt + 32'(close0) + 32'(close1);
            o_stat_pad_cnt <= o_stat_pad_cnt + 32'(pad0) + 32'(pad1);
        end
    end
`endif

endmodule
